// File: rtl/bfis_beam.sv
// Beam (best-first) graph-search controller: keeps an L-deep distance-sorted candidate
// list, expands the nearest unvisited entry, and streams the top-k entries when done.
// state   | meaning
// IDLE    | waiting for start_in
// SEED    | list reset to the seed vertex
// SELECT  | pick nearest unvisited slot or finish
// REQ     | expansion request outstanding
// COLLECT | merging neighbour beats into the list
// OUTPUT  | streaming top-k results
// DONE    | one-cycle completion pulse
module bfis_beam #(
  parameter int ID_W   = 32,
  parameter int DIST_W = 32,
  parameter int L      = 8,
  parameter int HOP_W  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ID_W-1:0]       entry_id_in,
  input  logic [DIST_W-1:0]     entry_dist_in,
  input  logic [$clog2(L):0]    k_in,
  input  logic [HOP_W-1:0]      max_hops_in,
  output logic                  req_valid_out,
  output logic [ID_W-1:0]       req_id_out,
  input  logic                  req_ready_in,
  input  logic                  nbr_valid_in,
  input  logic [ID_W-1:0]       nbr_id_in,
  input  logic [DIST_W-1:0]     nbr_dist_in,
  input  logic                  nbr_last_in,
  output logic                  nbr_ready_out,
  output logic                  res_valid_out,
  output logic [ID_W-1:0]       res_id_out,
  output logic [DIST_W-1:0]     res_dist_out,
  output logic                  res_last_out,
  input  logic                  res_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [HOP_W-1:0]      hops_out,
  output logic [2:0]            state_out
);

  localparam int IW = $clog2(L);
  localparam int CW = IW + 1;
  localparam logic [ID_W-1:0] NULL_ID = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_SELECT  = 3'd2,
    S_REQ     = 3'd3,
    S_COLLECT = 3'd4,
    S_OUTPUT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]   id_q   [L];
  logic [DIST_W-1:0] dist_q [L];
  logic [L-1:0]      vis_q;
  logic [ID_W-1:0]   id_d   [L];
  logic [DIST_W-1:0] dist_d [L];
  logic [L-1:0]      vis_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     k_eff_q;
  logic [HOP_W-1:0]  hops_q;
  logic [HOP_W-1:0]  max_hops_q;
  logic [ID_W-1:0]   seed_id_q;
  logic [DIST_W-1:0] seed_dist_q;
  logic [ID_W-1:0]   req_id_q;
  logic [IW-1:0]     out_idx_q;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          hop_lim;
  logic          dup;
  logic          full;
  logic          drop;
  logic          ins_found;
  logic [IW-1:0] ins_pos;
  logic [CW-1:0] res_n;
  logic          res_last;
  logic          beat_acc;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < L; i++) begin
      if (!sel_found && !vis_q[i] && (CW'(i) < cnt_q)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign hop_lim  = (max_hops_q != '0) && (hops_q == max_hops_q);
  assign res_n    = (k_eff_q < cnt_q) ? k_eff_q : cnt_q;
  assign res_last = (CW'(out_idx_q) == (res_n - CW'(1)));
  assign beat_acc = (state_q == S_COLLECT) && nbr_valid_in;

  // Sorted insert: ties resolve behind incumbents because only a strictly greater dist yields the slot.
  always_comb begin
    dup       = 1'b0;
    ins_found = 1'b0;
    ins_pos   = '0;
    for (int i = 0; i < L; i++) begin
      if (CW'(i) < cnt_q) begin
        if (id_q[i] == nbr_id_in) dup = 1'b1;
        if (!ins_found && (dist_q[i] > nbr_dist_in)) begin
          ins_found = 1'b1;
          ins_pos   = IW'(i);
        end
      end
    end
    if (!ins_found) ins_pos = IW'(cnt_q);
    full = (cnt_q == CW'(L));
    drop = (nbr_id_in == NULL_ID) || dup || (full && (nbr_dist_in >= dist_q[L-1]));

    id_d[0]   = (ins_pos == '0) ? nbr_id_in   : id_q[0];
    dist_d[0] = (ins_pos == '0) ? nbr_dist_in : dist_q[0];
    vis_d[0]  = (ins_pos == '0) ? 1'b0        : vis_q[0];
    for (int i = 1; i < L; i++) begin
      if (IW'(i) < ins_pos) begin
        id_d[i]   = id_q[i];
        dist_d[i] = dist_q[i];
        vis_d[i]  = vis_q[i];
      end else if (IW'(i) == ins_pos) begin
        id_d[i]   = nbr_id_in;
        dist_d[i] = nbr_dist_in;
        vis_d[i]  = 1'b0;
      end else begin
        id_d[i]   = id_q[i-1];
        dist_d[i] = dist_q[i-1];
        vis_d[i]  = vis_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_in) state_d = S_SEED;
      S_SEED:    state_d = S_SELECT;
      S_SELECT:  state_d = (!sel_found || hop_lim) ? S_OUTPUT : S_REQ;
      S_REQ:     if (req_ready_in) state_d = S_COLLECT;
      S_COLLECT: if (nbr_valid_in && nbr_last_in) state_d = S_SELECT;
      S_OUTPUT:  if (res_ready_in && res_last) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid_out = (state_q == S_REQ);
    nbr_ready_out = (state_q == S_COLLECT);
    res_valid_out = (state_q == S_OUTPUT);
    res_id_out    = '0;
    res_dist_out  = '0;
    res_last_out  = 1'b0;
    if (state_q == S_OUTPUT) begin
      res_id_out   = id_q[out_idx_q];
      res_dist_out = dist_q[out_idx_q];
      res_last_out = res_last;
    end
    busy_out   = (state_q != S_IDLE);
    done_out   = (state_q == S_DONE);
    hops_out   = hops_q;
    req_id_out = req_id_q;
    state_out  = state_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < L; i++) begin
        id_q[i]   <= '0;
        dist_q[i] <= '0;
      end
      vis_q       <= '0;
      cnt_q       <= '0;
      k_eff_q     <= '0;
      hops_q      <= '0;
      max_hops_q  <= '0;
      seed_id_q   <= '0;
      seed_dist_q <= '0;
      req_id_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_in) begin
          seed_id_q   <= entry_id_in;
          seed_dist_q <= entry_dist_in;
          max_hops_q  <= max_hops_in;
          if (k_in == '0)           k_eff_q <= CW'(1);
          else if (k_in > CW'(L))   k_eff_q <= CW'(L);
          else                      k_eff_q <= k_in;
        end
        S_SEED: begin
          id_q[0]   <= seed_id_q;
          dist_q[0] <= seed_dist_q;
          vis_q     <= '0;
          cnt_q     <= CW'(1);
          hops_q    <= '0;
          out_idx_q <= '0;
        end
        S_SELECT: if (sel_found && !hop_lim) begin
          vis_q[sel_idx] <= 1'b1;
          req_id_q       <= id_q[sel_idx];
          if (hops_q != '1) hops_q <= hops_q + HOP_W'(1);
        end
        S_COLLECT: if (beat_acc && !drop) begin
          id_q   <= id_d;
          dist_q <= dist_d;
          vis_q  <= vis_d;
          if (!full) cnt_q <= cnt_q + CW'(1);
        end
        S_OUTPUT: if (res_ready_in && !res_last) out_idx_q <= out_idx_q + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfis_beam.sv
// Directed bench for bfis_beam: an L=8 and an L=4 instance share stimulus, one selected at a time,
// with a hand-scripted fetch unit and hand-computed request/result expectations.
module tb_bfis_beam;

  localparam logic [31:0] NULL_ID = 32'hFFFF_FFFF;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        sel4;
  logic [31:0] entry_id_in, entry_dist_in;
  logic [3:0]  k_in;
  logic [15:0] max_hops_in;
  logic        req_ready_in, nbr_valid_in, nbr_last_in, res_ready_in;
  logic [31:0] nbr_id_in, nbr_dist_in;

  logic        a8_req_valid, a8_nbr_ready, a8_res_valid, a8_res_last, a8_busy, a8_done;
  logic [31:0] a8_req_id, a8_res_id, a8_res_dist;
  logic [15:0] a8_hops;
  logic [2:0]  a8_state;
  logic        a4_req_valid, a4_nbr_ready, a4_res_valid, a4_res_last, a4_busy, a4_done;
  logic [31:0] a4_req_id, a4_res_id, a4_res_dist;
  logic [15:0] a4_hops;
  logic [2:0]  a4_state;

  logic        req_valid, nbr_ready, res_valid, res_last, busy, done;
  logic [31:0] req_id, res_id, res_dist;
  logic [15:0] hops;
  logic [2:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] bq_id[$], bq_d[$], rq_id[$], rq_d[$];

  always #5 clk_in = ~clk_in;

  bfis_beam #(.ID_W(32), .DIST_W(32), .L(8), .HOP_W(16)) u_dut8 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in && !sel4),
    .entry_id_in(entry_id_in), .entry_dist_in(entry_dist_in), .k_in(k_in),
    .max_hops_in(max_hops_in), .req_valid_out(a8_req_valid), .req_id_out(a8_req_id),
    .req_ready_in(req_ready_in), .nbr_valid_in(nbr_valid_in), .nbr_id_in(nbr_id_in),
    .nbr_dist_in(nbr_dist_in), .nbr_last_in(nbr_last_in), .nbr_ready_out(a8_nbr_ready),
    .res_valid_out(a8_res_valid), .res_id_out(a8_res_id), .res_dist_out(a8_res_dist),
    .res_last_out(a8_res_last), .res_ready_in(res_ready_in), .busy_out(a8_busy),
    .done_out(a8_done), .hops_out(a8_hops), .state_out(a8_state));

  bfis_beam #(.ID_W(32), .DIST_W(32), .L(4), .HOP_W(16)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in && sel4),
    .entry_id_in(entry_id_in), .entry_dist_in(entry_dist_in), .k_in(k_in[2:0]),
    .max_hops_in(max_hops_in), .req_valid_out(a4_req_valid), .req_id_out(a4_req_id),
    .req_ready_in(req_ready_in), .nbr_valid_in(nbr_valid_in), .nbr_id_in(nbr_id_in),
    .nbr_dist_in(nbr_dist_in), .nbr_last_in(nbr_last_in), .nbr_ready_out(a4_nbr_ready),
    .res_valid_out(a4_res_valid), .res_id_out(a4_res_id), .res_dist_out(a4_res_dist),
    .res_last_out(a4_res_last), .res_ready_in(res_ready_in), .busy_out(a4_busy),
    .done_out(a4_done), .hops_out(a4_hops), .state_out(a4_state));

  always_comb begin
    if (sel4) begin
      req_valid = a4_req_valid; req_id = a4_req_id; nbr_ready = a4_nbr_ready;
      res_valid = a4_res_valid; res_id = a4_res_id; res_dist = a4_res_dist;
      res_last = a4_res_last; busy = a4_busy; done = a4_done; hops = a4_hops; state = a4_state;
    end else begin
      req_valid = a8_req_valid; req_id = a8_req_id; nbr_ready = a8_nbr_ready;
      res_valid = a8_res_valid; res_id = a8_res_id; res_dist = a8_res_dist;
      res_last = a8_res_last; busy = a8_busy; done = a8_done; hops = a8_hops; state = a8_state;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_search(input logic s4, input logic [31:0] id, input logic [31:0] d,
                              input logic [3:0] k, input logic [15:0] mh);
    sel4 = s4;
    entry_id_in = id; entry_dist_in = d; k_in = k; max_hops_in = mh;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("start_state_seed", {61'd0, state}, 64'd1);
    check("start_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic add_beat(input logic [31:0] id, input logic [31:0] d);
    bq_id.push_back(id);
    bq_d.push_back(d);
  endtask

  task automatic exp_res(input logic [31:0] id, input logic [31:0] d);
    rq_id.push_back(id);
    rq_d.push_back(d);
  endtask

  task automatic expand(input logic [31:0] exp_id, input int hold);
    int t = 0;
    int n;
    while (req_valid !== 1'b1 && t < 100) begin tick(); t++; end
    check("req_valid", {63'd0, req_valid}, 64'd1);
    check("req_id", {32'd0, req_id}, {32'd0, exp_id});
    for (int h = 0; h < hold; h++) begin
      tick();
      check("req_hold_valid", {63'd0, req_valid}, 64'd1);
      check("req_hold_id", {32'd0, req_id}, {32'd0, exp_id});
    end
    req_ready_in = 1'b1;
    tick();
    req_ready_in = 1'b0;
    check("req_valid_drop", {63'd0, req_valid}, 64'd0);
    check("collect_nbr_ready", {63'd0, nbr_ready}, 64'd1);
    n = bq_id.size();
    for (int i = 0; i < n; i++) begin
      nbr_valid_in = 1'b1;
      nbr_id_in    = bq_id[i];
      nbr_dist_in  = bq_d[i];
      nbr_last_in  = (i == n - 1);
      tick();
    end
    nbr_valid_in = 1'b0;
    nbr_last_in  = 1'b0;
    bq_id.delete();
    bq_d.delete();
  endtask

  task automatic get_results(input bit bp);
    int t = 0;
    int n;
    n = rq_id.size();
    while (res_valid !== 1'b1 && t < 100) begin tick(); t++; end
    check("res_wait_valid", {63'd0, res_valid}, 64'd1);
    for (int i = 0; i < n; i++) begin
      if (bp) begin
        res_ready_in = 1'b0;
        tick();
        check("res_bp_valid", {63'd0, res_valid}, 64'd1);
        check("res_bp_id", {32'd0, res_id}, {32'd0, rq_id[i]});
      end
      res_ready_in = 1'b1;
      check("res_valid", {63'd0, res_valid}, 64'd1);
      check("res_id", {32'd0, res_id}, {32'd0, rq_id[i]});
      check("res_dist", {32'd0, res_dist}, {32'd0, rq_d[i]});
      check("res_last", {63'd0, res_last}, {63'd0, (i == n - 1)});
      tick();
      res_ready_in = 1'b0;
    end
    check("done_pulse", {63'd0, done}, 64'd1);
    tick();
    check("done_low", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    rq_id.delete();
    rq_d.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; start_in = 1'b0; sel4 = 1'b0;
    entry_id_in = '0; entry_dist_in = '0; k_in = '0; max_hops_in = '0;
    req_ready_in = 1'b0; nbr_valid_in = 1'b0; nbr_last_in = 1'b0; res_ready_in = 1'b0;
    nbr_id_in = '0; nbr_dist_in = '0;
    tick(); tick();
    check("rst_state", {61'd0, state}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hops", {48'd0, hops}, 64'd0);
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_state4", {61'd0, a4_state}, 64'd0);
    rst_in = 1'b0;
    tick();

    // 1: seed only
    start_search(1'b0, 32'd5, 32'd100, 4'd4, 16'd0);
    add_beat(NULL_ID, 32'd0); expand(32'd5, 0);
    tick();
    check("s1_no_more_req", {61'd0, state}, 64'd5);
    check("s1_hops", {48'd0, hops}, 64'd1);
    exp_res(32'd5, 32'd100);
    get_results(1'b0);

    // 2: ordering
    start_search(1'b0, 32'd0, 32'd50, 4'd3, 16'd0);
    add_beat(32'd1, 32'd30); add_beat(32'd2, 32'd70); add_beat(32'd3, 32'd10); expand(32'd0, 0);
    add_beat(32'd4, 32'd5); expand(32'd3, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd4, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd1, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd2, 0);
    check("s2_hops", {48'd0, hops}, 64'd5);
    exp_res(32'd4, 32'd5); exp_res(32'd3, 32'd10); exp_res(32'd1, 32'd30);
    get_results(1'b0);

    // 3: eviction on the L=4 instance, k clamped from 7 to 4
    start_search(1'b1, 32'd0, 32'd50, 4'd7, 16'd0);
    add_beat(32'd1, 32'd40); add_beat(32'd2, 32'd30); add_beat(32'd3, 32'd20);
    add_beat(32'd4, 32'd10); add_beat(32'd5, 32'd60); expand(32'd0, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd4, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd3, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd2, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd1, 0);
    check("s3_hops", {48'd0, hops}, 64'd5);
    exp_res(32'd4, 32'd10); exp_res(32'd3, 32'd20); exp_res(32'd2, 32'd30); exp_res(32'd1, 32'd40);
    get_results(1'b0);

    // 4: duplicates and ties
    start_search(1'b0, 32'd0, 32'd50, 4'd8, 16'd0);
    add_beat(32'd2, 32'd40); add_beat(32'd0, 32'd99); add_beat(32'd2, 32'd45);
    add_beat(32'd7, 32'd40); expand(32'd0, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd2, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd7, 0);
    check("s4_hops", {48'd0, hops}, 64'd3);
    exp_res(32'd2, 32'd40); exp_res(32'd7, 32'd40); exp_res(32'd0, 32'd50);
    get_results(1'b0);

    // 5: hop limit, k=0 yields one result
    start_search(1'b0, 32'd0, 32'd50, 4'd0, 16'd2);
    add_beat(32'd1, 32'd30); add_beat(32'd2, 32'd70); add_beat(32'd3, 32'd10); expand(32'd0, 0);
    add_beat(32'd4, 32'd5); expand(32'd3, 0);
    tick();
    check("s5_no_more_req", {61'd0, state}, 64'd5);
    check("s5_hops", {48'd0, hops}, 64'd2);
    exp_res(32'd4, 32'd5);
    get_results(1'b0);

    // 6a: request and result backpressure
    start_search(1'b0, 32'd9, 32'd20, 4'd2, 16'd0);
    add_beat(32'd10, 32'd15); add_beat(32'd11, 32'd25); expand(32'd9, 5);
    add_beat(NULL_ID, 32'd0); expand(32'd10, 0);
    add_beat(NULL_ID, 32'd0); expand(32'd11, 0);
    exp_res(32'd10, 32'd15); exp_res(32'd9, 32'd20);
    get_results(1'b1);

    // 6b: asynchronous reset mid-COLLECT
    start_search(1'b0, 32'd1, 32'd10, 4'd1, 16'd0);
    begin
      int t = 0;
      while (req_valid !== 1'b1 && t < 100) begin tick(); t++; end
    end
    check("s6_req_id", {32'd0, req_id}, 64'd1);
    req_ready_in = 1'b1; tick(); req_ready_in = 1'b0;
    nbr_valid_in = 1'b1; nbr_id_in = 32'd2; nbr_dist_in = 32'd5; nbr_last_in = 1'b0;
    tick();
    check("s6_mid_collect", {61'd0, state}, 64'd4);
    #2 rst_in = 1'b1;
    #1;
    nbr_valid_in = 1'b0;
    check("s6_rst_state", {61'd0, state}, 64'd0);
    check("s6_rst_busy", {63'd0, busy}, 64'd0);
    check("s6_rst_nbr_ready", {63'd0, nbr_ready}, 64'd0);
    check("s6_rst_req_id", {32'd0, req_id}, 64'd0);
    check("s6_rst_hops", {48'd0, hops}, 64'd0);
    check("s6_rst_res_valid", {63'd0, res_valid}, 64'd0);
    tick(); tick();
    rst_in = 1'b0;
    tick();
    start_search(1'b0, 32'd3, 32'd33, 4'd1, 16'd0);
    add_beat(NULL_ID, 32'd0); expand(32'd3, 0);
    check("s6_clean_hops", {48'd0, hops}, 64'd1);
    exp_res(32'd3, 32'd33);
    get_results(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
